// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the fetch stage and its queues.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; holds fetched words or PC tags.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  input  logic                           flush,
  output logic [WIDTH-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A pop frees the head slot in the same cycle, so a full FIFO may push and pop together.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  assert property (@(posedge clk) disable iff (reset) !(push && !flush && full && !do_pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests, response queue and redirect flush.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic          req_fire;
  logic          head_fire;
  logic          rsp_keep;
  logic [CW:0]   credit_used;

  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic [CW-1:0] q_count;
  logic          q_empty;
  logic          q_full;

  logic [31:0]   tag_head;
  logic [CW-1:0] tag_count;
  logic          tag_empty;
  logic          tag_full;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign head_fire = !q_empty && instr_ready;
  assign rsp_keep  = imem_rsp_valid && !redirect_valid && (discard == '0);

  // The head leaving this cycle returns its credit immediately; otherwise a
  // 2-entry queue could only sustain one instruction every other cycle.
  assign credit_used    = {1'b0, q_count} - (CW+1)'(head_fire) + {1'b0, outstanding};
  assign imem_req_valid = !reset && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr      = fetch_pc;

  assign push_entry = '{pc: tag_head, instr: imem_rsp_data};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (head_fire),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // Tags track every accepted request, including ones later discarded, so they
  // are never flushed and always pop on a response.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .head_data (tag_head),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= word_align(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
        discard  <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  assign instr_valid = !q_empty;
  assign Instr       = q_empty ? NOP_INSTR : head.instr;
  assign PC          = q_empty ? 32'h0 : head.pc;
  assign PCPlus4     = q_empty ? 32'h0 : head.pc + 32'd4;

  assert property (@(posedge clk) disable iff (reset) imem_rsp_valid |-> !tag_empty);
  assert property (@(posedge clk) disable iff (reset) req_fire |-> !tag_full);
  assert property (@(posedge clk) disable iff (reset) outstanding == tag_count);
  assert property (@(posedge clk) disable iff (reset) (rsp_keep && q_full) |-> head_fire);

endmodule
